// File: rtl/contador_pkg.sv
// Shared types and parameter limits for the contador_multi counter bank.
// Optional macro CONTADOR_GRAY_EN adds a registered Gray-coded output per channel.
package contador_pkg;

  typedef enum logic [1:0] {
    UP       = 2'b00,
    DOWN     = 2'b01,
    PINGPONG = 2'b10,
    HOLD     = 2'b11
  } cnt_mode_t;

  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_LIM    = 16;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_LIM = 8;
  localparam int MAX_MIN      = 1;

  function automatic int max_limit(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/contador_core.sv
// One counter channel: UP / DOWN / PINGPONG / HOLD with load, terminal pulse and direction.
// With CONTADOR_GRAY_EN defined, o_s_gray carries the registered Gray code of o_s.
module contador_core
  import contador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_en,
  input  cnt_mode_t        i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_s,
  output logic             o_tc,
  output logic             o_dir
`ifdef CONTADOR_GRAY_EN
  ,
  output logic [WIDTH-1:0] o_s_gray
`endif
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  logic [WIDTH-1:0] r_s, w_s_nxt, w_up, w_dn;
  logic             r_tc, w_tc_nxt;
  logic             r_dir, w_dir_nxt;

  assign w_up = r_s + 1'b1;
  assign w_dn = r_s - 1'b1;

  always_comb begin
    w_s_nxt   = r_s;
    w_tc_nxt  = 1'b0;
    w_dir_nxt = r_dir;
    if (i_load) begin
      w_s_nxt = (i_load_val > MAXV) ? MAXV : i_load_val;
    end else if (i_en) begin
      unique case (i_mode)
        UP: begin
          w_dir_nxt = 1'b1;
          if (r_s >= MAXV) begin
            w_s_nxt  = '0;
            w_tc_nxt = 1'b1;
          end else begin
            w_s_nxt = w_up;
          end
        end
        DOWN: begin
          w_dir_nxt = 1'b0;
          if (r_s == '0) begin
            w_s_nxt  = MAXV;
            w_tc_nxt = 1'b1;
          end else begin
            w_s_nxt = w_dn;
          end
        end
        PINGPONG: begin
          // Already sitting on the bound it is heading for: bounce straight back.
          if (r_dir && r_s >= MAXV) begin
            w_s_nxt   = w_dn;
            w_dir_nxt = 1'b0;
            w_tc_nxt  = 1'b1;
          end else if (!r_dir && r_s == '0) begin
            w_s_nxt   = w_up;
            w_dir_nxt = 1'b1;
            w_tc_nxt  = 1'b1;
          end else if (r_dir) begin
            w_s_nxt = w_up;
            if (w_up == MAXV) begin
              w_dir_nxt = 1'b0;
              w_tc_nxt  = 1'b1;
            end
          end else begin
            w_s_nxt = w_dn;
            if (w_dn == '0) begin
              w_dir_nxt = 1'b1;
              w_tc_nxt  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s   <= '0;
      r_tc  <= 1'b0;
      r_dir <= 1'b1;
    end else if (i_run) begin
      r_s   <= w_s_nxt;
      r_tc  <= w_tc_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign o_s   = r_s;
  assign o_tc  = r_tc;
  assign o_dir = r_dir;

`ifdef CONTADOR_GRAY_EN
  logic [WIDTH-1:0] r_gray;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_gray <= '0;
    else if (i_run) r_gray <= w_s_nxt ^ (w_s_nxt >> 1);
  end

  assign o_s_gray = r_gray;
`endif

endmodule

// File: rtl/contador_multi.sv
// Bank of CHANNELS independent counters sharing clock, reset and load value.
// Optional macro CONTADOR_GRAY_EN adds the s_gray output.
module contador_multi
  import contador_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 9,
  parameter int CHANNELS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic      [CHANNELS-1:0]       en,
  input  cnt_mode_t [CHANNELS-1:0]       mode,
  input  logic      [CHANNELS-1:0]       load,
  input  logic      [WIDTH-1:0]          load_val,
  output logic      [CHANNELS-1:0][WIDTH-1:0] s,
  output logic      [CHANNELS-1:0]       tc,
  output logic      [CHANNELS-1:0]       dir
`ifdef CONTADOR_GRAY_EN
  ,
  output logic      [CHANNELS-1:0][WIDTH-1:0] s_gray
`endif
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_LIM) begin : g_bad_width
    $error("contador_multi: WIDTH out of range");
  end
  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_LIM) begin : g_bad_channels
    $error("contador_multi: CHANNELS out of range");
  end
  if (MAX < MAX_MIN || MAX > max_limit(WIDTH)) begin : g_bad_max
    $error("contador_multi: MAX out of range");
  end

  // Reset assertion is immediate; release is retimed so cores start on the second edge.
  logic r_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    contador_core #(
      .WIDTH(WIDTH),
      .MAX  (MAX)
    ) u_core (
      .clk       (clk),
      .rst       (rst),
      .i_run     (r_run),
      .i_en      (en[g]),
      .i_mode    (mode[g]),
      .i_load    (load[g]),
      .i_load_val(load_val),
      .o_s       (s[g]),
      .o_tc      (tc[g]),
      .o_dir     (dir[g])
`ifdef CONTADOR_GRAY_EN
      ,
      .o_s_gray  (s_gray[g])
`endif
    );
  end

endmodule
